// File: rtl/ecc_ff_inv.sv
// GF(2^m) polynomial-basis inverter using the binary extended Euclidean algorithm, one step per clock.
// Optional iteration watchdog enabled by defining ECC_FF_INV_WDOG_EN.
module ecc_ff_inv #(
  parameter int unsigned m      = 163,
  parameter logic [m:0]  F_POLY = 164'h8_0000_0000_0000_0000_0000_0000_0000_0000_0000_00C9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [m-1:0] a,
  output logic         busy,
  output logic         done,
  output logic [m-1:0] q,
  output logic         err
);

  typedef enum logic [1:0] {IDLE, LOOP, DONE} state_t;

  localparam logic [m:0]   ONE_U = {{m{1'b0}}, 1'b1};
  localparam logic [m-1:0] ONE_G = {{(m-1){1'b0}}, 1'b1};

  state_t       state, state_d;
  logic [m:0]   u, v, u_d, v_d;
  logic [m-1:0] g1, g2, g1_d, g2_d, q_d;
  logic         busy_d, done_d, err_d;

`ifdef ECC_FF_INV_WDOG_EN
  localparam int unsigned WDOG_LIMIT = 4 * m + 2;
  localparam int unsigned CW = $clog2(WDOG_LIMIT);
  logic [CW-1:0] cnt, cnt_d;
`endif

  // g * x^-1 mod F: add F first when g is odd so the shifted-out bit is zero.
  function automatic logic [m-1:0] half_mod(input logic [m-1:0] g);
    logic [m:0] t;
    t = {1'b0, g} ^ (g[0] ? F_POLY : '0);
    return t[m:1];
  endfunction

  always_comb begin
    state_d = state;
    u_d     = u;
    v_d     = v;
    g1_d    = g1;
    g2_d    = g2;
    q_d     = q;
    err_d   = err;
    done_d  = 1'b0;
`ifdef ECC_FF_INV_WDOG_EN
    cnt_d   = cnt;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          if (a != '0) begin
            u_d     = {1'b0, a};
            v_d     = F_POLY;
            g1_d    = ONE_G;
            g2_d    = '0;
            state_d = LOOP;
`ifdef ECC_FF_INV_WDOG_EN
            cnt_d   = '0;
`endif
          end else begin
            q_d    = '0;
            err_d  = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      LOOP: begin
        if (u == ONE_U) begin
          q_d     = g1;
          err_d   = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (v == ONE_U) begin
          q_d     = g2;
          err_d   = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (!u[0]) begin
          u_d  = u >> 1;
          g1_d = half_mod(g1);
        end else if (!v[0]) begin
          v_d  = v >> 1;
          g2_d = half_mod(g2);
        end else if (u > v) begin
          u_d  = u ^ v;
          g1_d = g1 ^ g2;
        end else begin
          v_d  = v ^ u;
          g2_d = g2 ^ g1;
        end
`ifdef ECC_FF_INV_WDOG_EN
        cnt_d = cnt + 1'b1;
        // Abort in LOOP cycle 4m+1 so done lands exactly 4m+2 cycles after start.
        if (state_d == LOOP && cnt == CW'(WDOG_LIMIT - 2)) begin
          q_d     = '0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end
`endif
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == LOOP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      u     <= '0;
      v     <= '0;
      g1    <= '0;
      g2    <= '0;
      q     <= '0;
      err   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef ECC_FF_INV_WDOG_EN
      cnt   <= '0;
`endif
    end else begin
      state <= state_d;
      u     <= u_d;
      v     <= v_d;
      g1    <= g1_d;
      g2    <= g2_d;
      q     <= q_d;
      err   <= err_d;
      busy  <= busy_d;
      done  <= done_d;
`ifdef ECC_FF_INV_WDOG_EN
      cnt   <= cnt_d;
`endif
    end
  end

endmodule
